// File: rtl/serial_mag_comp.sv
// -----------------------------------------------------------------------------
// serial_mag_comp
//
// Sequential magnitude comparator for two WIDTH-bit operands. The operands are
// latched on the accepting edge and compared MSB-first, DIGIT bits per clock,
// using an L/E/G cascade. The run stops on the first unequal digit, or after
// NDIG = WIDTH/DIGIT steps when the operands are equal.
//
// Optional build feature:
//   SERIAL_MAG_COMP_SIGNED_EN - adds the sgn input. When the latched sgn is 1,
//   the operands are compared as two's complement by inverting the MSB of both
//   latched operands (offset-binary). Undefined: unsigned comparison only.
//
// Parameters:
//   WIDTH  operand width in bits (>= 1)
//   DIGIT  bits compared per clock (>= 1, must divide WIDTH)
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high reset
//   start  in   1      request, sampled only while idle
//   sgn    in   1      signed compare select (SERIAL_MAG_COMP_SIGNED_EN only)
//   A      in   WIDTH  operand A, sampled on the accepting edge
//   B      in   WIDTH  operand B, sampled on the accepting edge
//   busy   out  1      comparison in progress
//   done   out  1      one-cycle pulse, L/E/G valid from this cycle
//   L      out  1      A <  B (held until the next finish or reset)
//   E      out  1      A == B (held until the next finish or reset)
//   G      out  1      A >  B (held until the next finish or reset)
// -----------------------------------------------------------------------------
module serial_mag_comp #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SERIAL_MAG_COMP_SIGNED_EN
    input  logic             sgn,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             L,
    output logic             E,
    output logic             G
);

    // Guarded so that a bad DIGIT reaches the elaboration error below
    // instead of a divide-by-zero inside the localparam.
    localparam int NDIG  = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("serial_mag_comp: WIDTH must be >= 1");
        end
        if (DIGIT < 1) begin : g_bad_digit
            $error("serial_mag_comp: DIGIT must be >= 1");
        end else if ((WIDTH % DIGIT) != 0) begin : g_bad_divide
            $error("serial_mag_comp: DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Flip the MSB when comparing signed values: two's complement then orders
    // correctly under a plain unsigned compare.
    function automatic logic [WIDTH-1:0] offset_bin(input logic [WIDTH-1:0] v,
                                                    input logic             s);
        logic [WIDTH-1:0] r;
        r            = v;
        r[WIDTH-1]   = v[WIDTH-1] ^ s;
        return r;
    endfunction

    state_t           state_r;
    state_t           state_n;

    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sa_n;
    logic [WIDTH-1:0] sb_n;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n;

    // Running cascade for the current comparison.
    logic             lc_r;
    logic             ec_r;
    logic             gc_r;
    logic             lc_n;
    logic             ec_n;
    logic             gc_n;

    // Registered outputs.
    logic             busy_r;
    logic             done_r;
    logic             l_r;
    logic             e_r;
    logic             g_r;
    logic             busy_n;
    logic             done_n;
    logic             l_n;
    logic             e_n;
    logic             g_n;

    logic             sgn_s;
    logic [DIGIT-1:0] da_s;
    logic [DIGIT-1:0] db_s;
    logic             dig_lt_s;
    logic             dig_gt_s;
    logic             step_lc_s;
    logic             step_ec_s;
    logic             step_gc_s;
    logic             accept_s;
    logic             finish_s;

`ifdef SERIAL_MAG_COMP_SIGNED_EN
    assign sgn_s = sgn;
`else
    assign sgn_s = 1'b0;
`endif

    // Digit under test is always the top DIGIT bits; the registers shift left.
    assign da_s     = sa_r[WIDTH-1 -: DIGIT];
    assign db_s     = sb_r[WIDTH-1 -: DIGIT];
    assign dig_lt_s = (da_s < db_s);
    assign dig_gt_s = (da_s > db_s);

    // Cascade after the current step. Once Ec drops the run finishes, so
    // later digits never get a chance to override an earlier decision.
    assign step_lc_s = lc_r | (ec_r & dig_lt_s);
    assign step_gc_s = gc_r | (ec_r & dig_gt_s);
    assign step_ec_s = ec_r & ~(dig_lt_s | dig_gt_s);

    assign accept_s = (state_r == ST_IDLE) & start;
    assign finish_s = (state_r == ST_RUN) &
                      (dig_lt_s | dig_gt_s | (cnt_r == LAST_CNT));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic: idle until start, run until a decision or the last digit.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (finish_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output/datapath logic: next values for the shift registers, counter,
    // cascade and the registered outputs.
    always_comb begin
        sa_n   = sa_r;
        sb_n   = sb_r;
        cnt_n  = cnt_r;
        lc_n   = lc_r;
        ec_n   = ec_r;
        gc_n   = gc_r;
        busy_n = busy_r;
        done_n = 1'b0;
        l_n    = l_r;
        e_n    = e_r;
        g_n    = g_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    sa_n   = offset_bin(A, sgn_s);
                    sb_n   = offset_bin(B, sgn_s);
                    cnt_n  = {CNT_W{1'b0}};
                    lc_n   = 1'b0;
                    ec_n   = 1'b1;
                    gc_n   = 1'b0;
                    busy_n = 1'b1;
                end else begin
                    busy_n = 1'b0;
                end
            end
            ST_RUN: begin
                sa_n = sa_r << DIGIT;
                sb_n = sb_r << DIGIT;
                lc_n = step_lc_s;
                ec_n = step_ec_s;
                gc_n = step_gc_s;
                if (finish_s) begin
                    cnt_n  = {CNT_W{1'b0}};
                    busy_n = 1'b0;
                    done_n = 1'b1;
                    l_n    = step_lc_s;
                    e_n    = step_ec_s;
                    g_n    = step_gc_s;
                end else begin
                    cnt_n  = cnt_r + CNT_ONE;
                    busy_n = 1'b1;
                end
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset leaves L/E/G all zero ("no result").
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa_r   <= {WIDTH{1'b0}};
            sb_r   <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            lc_r   <= 1'b0;
            ec_r   <= 1'b0;
            gc_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            l_r    <= 1'b0;
            e_r    <= 1'b0;
            g_r    <= 1'b0;
        end else begin
            sa_r   <= sa_n;
            sb_r   <= sb_n;
            cnt_r  <= cnt_n;
            lc_r   <= lc_n;
            ec_r   <= ec_n;
            gc_r   <= gc_n;
            busy_r <= busy_n;
            done_r <= done_n;
            l_r    <= l_n;
            e_r    <= e_n;
            g_r    <= g_n;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign L    = l_r;
    assign E    = e_r;
    assign G    = g_r;

endmodule

// File: tb/tb_serial_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comp
//
// Scoreboard bench for serial_mag_comp. Two instances: WIDTH=8/DIGIT=1 and
// WIDTH=8/DIGIT=4. Stimulus tasks push the hand-computed result and the
// expected number of compare cycles into a per-instance queue; monitors pop
// and compare whenever done is seen. Signed cases run when
// SERIAL_MAG_COMP_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_mag_comp;

    typedef struct {
        logic l;
        logic e;
        logic g;
        int   lat;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start1;
    logic       start4;
    logic       sgn1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic [7:0] a4;
    logic [7:0] b4;
    logic       busy1, done1, l1, e1, g1;
    logic       busy4, done4, l4, e4, g4;

    exp_t       q1[$];
    exp_t       q4[$];
    int         tests;
    int         fails;
    logic       pl, pe, pg;

    serial_mag_comp #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
`ifdef SERIAL_MAG_COMP_SIGNED_EN
        .sgn   (sgn1),
`endif
        .A     (a1),
        .B     (b1),
        .busy  (busy1),
        .done  (done1),
        .L     (l1),
        .E     (e1),
        .G     (g1)
    );

    serial_mag_comp #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk   (clk),
        .reset (reset),
        .start (start4),
`ifdef SERIAL_MAG_COMP_SIGNED_EN
        .sgn   (1'b0),
`endif
        .A     (a4),
        .B     (b4),
        .busy  (busy4),
        .done  (done4),
        .L     (l4),
        .E     (e4),
        .G     (g4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: busy still high after cycle budget, required to drop", name);
    endtask

    // Monitor for the DIGIT=1 instance.
    initial begin : mon1
        int   bc;
        exp_t ex;
        bc = 0;
        forever begin
            @(negedge clk);
            check("d1_onehot_invariant", 32'(l1) + 32'(e1) + 32'(g1) <= 32'd1, 32'd1);
            if (reset) begin
                bc = 0;
            end else begin
                if (busy1) bc++;
                if (done1) begin
                    if (q1.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL d1_unexpected_done: got done with no run pending, required none");
                    end else begin
                        ex = q1.pop_front();
                        check("d1_L", 32'(l1), 32'(ex.l));
                        check("d1_E", 32'(e1), 32'(ex.e));
                        check("d1_G", 32'(g1), 32'(ex.g));
                        check("d1_busy_cycles", bc, ex.lat);
                    end
                    bc = 0;
                end
            end
        end
    end

    // Monitor for the DIGIT=4 instance.
    initial begin : mon4
        int   bc;
        exp_t ex;
        bc = 0;
        forever begin
            @(negedge clk);
            check("d4_onehot_invariant", 32'(l4) + 32'(e4) + 32'(g4) <= 32'd1, 32'd1);
            if (reset) begin
                bc = 0;
            end else begin
                if (busy4) bc++;
                if (done4) begin
                    if (q4.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL d4_unexpected_done: got done with no run pending, required none");
                    end else begin
                        ex = q4.pop_front();
                        check("d4_L", 32'(l4), 32'(ex.l));
                        check("d4_E", 32'(e4), 32'(ex.e));
                        check("d4_G", 32'(g4), 32'(ex.g));
                        check("d4_busy_cycles", bc, ex.lat);
                    end
                    bc = 0;
                end
            end
        end
    end

    task automatic wait_idle1();
        int t;
        t = 0;
        while (busy1 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 40) timeout_fail("d1_timeout");
    endtask

    task automatic wait_idle4();
        int t;
        t = 0;
        while (busy4 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 40) timeout_fail("d4_timeout");
    endtask

    // One run on the DIGIT=1 instance; also checks L/E/G hold across accept.
    task automatic cmp1(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic xl, input logic xe, input logic xg, input int lat);
        q1.push_back('{xl, xe, xg, lat});
        @(posedge clk);
        #1;
        a1     = a;
        b1     = b;
        sgn1   = s;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("d1_busy_after_accept", 32'(busy1), 32'd1);
        check("d1_LEG_held_at_accept", {29'd0, l1, e1, g1}, {29'd0, pl, pe, pg});
        wait_idle1();
        pl = xl;
        pe = xe;
        pg = xg;
    endtask

    task automatic cmp4(input logic [7:0] a, input logic [7:0] b,
                        input logic xl, input logic xe, input logic xg, input int lat);
        q4.push_back('{xl, xe, xg, lat});
        @(posedge clk);
        #1;
        a4     = a;
        b4     = b;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        wait_idle4();
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        pl     = 1'b0;
        pe     = 1'b0;
        pg     = 1'b0;
        reset  = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        sgn1   = 1'b0;
        a1     = 8'h00;
        b1     = 8'h00;
        a4     = 8'h00;
        b4     = 8'h00;

        #12;
        check("reset_busy1", 32'(busy1), 32'd0);
        check("reset_done1", 32'(done1), 32'd0);
        check("reset_LEG1", {29'd0, l1, e1, g1}, 32'd0);
        check("reset_busy4", 32'(busy4), 32'd0);
        check("reset_LEG4", {29'd0, l4, e4, g4}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // DIGIT=1 directed vectors.
        cmp1(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8);
        cmp1(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        cmp1(8'h40, 8'h60, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        cmp1(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        cmp1(8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8);
        cmp1(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8);

        // start held through the run; A changed while busy must not matter.
        // The held start then launches FF vs 13 on the first idle edge.
        q1.push_back('{1'b1, 1'b0, 1'b0, 8});
        q1.push_back('{1'b0, 1'b0, 1'b1, 1});
        @(posedge clk);
        #1;
        a1     = 8'h12;
        b1     = 8'h13;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        a1 = 8'hFF;
        wait_idle1();
        check("held_start_L_after_first", 32'(l1), 32'd1);
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("held_start_rerun_busy", 32'(busy1), 32'd1);
        wait_idle1();
        pl = 1'b0;
        pe = 1'b0;
        pg = 1'b1;

        // Asynchronous reset in the middle of step 3 of a long run.
        @(posedge clk);
        #1;
        a1     = 8'h00;
        b1     = 8'h01;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrun_reset_busy", 32'(busy1), 32'd0);
        check("midrun_reset_done", 32'(done1), 32'd0);
        check("midrun_reset_LEG", {29'd0, l1, e1, g1}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("after_reset_idle", 32'(busy1), 32'd0);
        pl = 1'b0;
        pe = 1'b0;
        pg = 1'b0;
        cmp1(8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 8);

`ifdef SERIAL_MAG_COMP_SIGNED_EN
        cmp1(8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        cmp1(8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        cmp1(8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 8);
`endif

        // DIGIT=4 directed vectors.
        cmp4(8'h3C, 8'h3D, 1'b1, 1'b0, 1'b0, 2);
        cmp4(8'hA0, 8'h3F, 1'b0, 1'b0, 1'b1, 1);
        cmp4(8'h77, 8'h77, 1'b0, 1'b1, 1'b0, 2);
        cmp4(8'h5E, 8'h5B, 1'b0, 1'b0, 1'b1, 2);
        check("d4_LEG_hold_after_done", {29'd0, l4, e4, g4}, 32'd1);

        repeat (4) @(posedge clk);
        #1;
        check("d1_all_results_seen", q1.size(), 32'd0);
        check("d4_all_results_seen", q4.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
